// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register for the 5-stage RISC-V core.
// Captures the ALU result, store data, destination register and MEM/WB control
// bits. Supports stall (hold) and flush (bubble), and feeds forwarding info back
// to EX. Define EXMEM_BRANCH_RESOLVE_EN to resolve BEQ/BNE here; otherwise
// mem_pc_src and mem_branch_target are tied to 0.
module ex_mem_pipe_reg #(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [N-1:0]    ex_alu_out,
  input  logic            ex_zero,
  input  logic [N-1:0]    ex_rs2_data,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [N-1:0]    ex_branch_target,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic            ex_branch,
  output logic            mem_valid,
  output logic [N-1:0]    mem_alu_out,
  output logic [N-1:0]    mem_rs2_data,
  output logic [RA_W-1:0] mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            mem_pc_src,
  output logic [N-1:0]    mem_branch_target,
  output logic [RA_W-1:0] fwd_rd,
  output logic            fwd_en
);

  logic            valid_q, valid_d;
  logic [N-1:0]    alu_q, alu_d;
  logic [N-1:0]    rs2_q, rs2_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;

  // Next state for the core fields: flush clears control, stall holds, else load.
  always_comb begin
    valid_d      = valid_q;
    alu_d        = alu_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!stall) begin
      valid_d      = ex_valid;
      alu_d        = ex_alu_out;
      rs2_d        = ex_rs2_data;
      rd_d         = ex_rd;
      // x0 is never written, so it is never a forwarding source either.
      reg_write_d  = ex_valid & ex_reg_write & (ex_rd != '0);
      mem_read_d   = ex_valid & ex_mem_read;
      mem_write_d  = ex_valid & ex_mem_write;
      mem_to_reg_d = ex_valid & ex_mem_to_reg;
    end
  end

  // Core state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

`ifdef EXMEM_BRANCH_RESOLVE_EN
  logic         pc_src_q, pc_src_d;
  logic [N-1:0] target_q, target_d;
  logic         unused_cfg;

  assign unused_cfg = 1'b0;

  // Branch decision: BEQ takes on zero, BNE on non-zero, other funct3 never.
  always_comb begin
    pc_src_d = pc_src_q;
    target_d = target_q;
    if (flush) begin
      pc_src_d = 1'b0;
    end else if (!stall) begin
      pc_src_d = ex_valid & ex_branch &
                 (((ex_funct3 == 3'b000) & ex_zero) |
                  ((ex_funct3 == 3'b001) & ~ex_zero));
      target_d = ex_branch_target;
    end
  end

  // Branch state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_src_q <= 1'b0;
      target_q <= '0;
    end else begin
      pc_src_q <= pc_src_d;
      target_q <= target_d;
    end
  end

  assign mem_pc_src        = pc_src_q;
  assign mem_branch_target = target_q;
`else
  logic unused_cfg;

  // Branch inputs are ignored when branch resolution lives elsewhere.
  assign unused_cfg        = ^{ex_zero, ex_funct3, ex_branch_target, ex_branch};
  assign mem_pc_src        = 1'b0;
  assign mem_branch_target = '0;
`endif

  assign mem_valid      = valid_q;
  assign mem_alu_out    = alu_q;
  assign mem_rs2_data   = rs2_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign fwd_rd         = rd_q;
  assign fwd_en         = reg_write_q & ~mem_read_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: each driven cycle pushes the expected
// register contents, which are popped and compared one clock later.
module tb_ex_mem_pipe_reg;
  localparam int N    = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall, flush, ex_valid, ex_zero;
  logic [N-1:0]    ex_alu_out, ex_rs2_data, ex_branch_target;
  logic [RA_W-1:0] ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic            mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic            mem_pc_src, fwd_en;
  logic [N-1:0]    mem_alu_out, mem_rs2_data, mem_branch_target;
  logic [RA_W-1:0] mem_rd, fwd_rd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic stall, flush, v, zero, rw, mr, mw, m2r, br;
    logic [N-1:0] alu, rs2, tgt;
    logic [RA_W-1:0] rd;
    logic [2:0] f3;
  } in_t;

  typedef struct {
    logic v, rw, mr, mw, m2r, pcs;
    logic [N-1:0] alu, rs2, tgt;
    logic [RA_W-1:0] rd;
    logic data_known;
  } exp_t;

  exp_t model;
  exp_t sb[$];

  ex_mem_pipe_reg #(.N(N), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_branch_target(ex_branch_target), .ex_funct3(ex_funct3),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_rs2_data(mem_rs2_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_pc_src(mem_pc_src), .mem_branch_target(mem_branch_target),
    .fwd_rd(fwd_rd), .fwd_en(fwd_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t zero_state();
    exp_t e;
    e.v = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.pcs = 0;
    e.alu = '0; e.rs2 = '0; e.tgt = '0; e.rd = '0; e.data_known = 1'b1;
    return e;
  endfunction

  function automatic in_t ld(input logic v, input logic [N-1:0] alu, input logic [RA_W-1:0] rd,
                             input logic rw, input logic mr, input logic mw, input logic m2r);
    in_t s;
    s.stall = 0; s.flush = 0; s.v = v; s.alu = alu; s.rd = rd;
    s.rw = rw; s.mr = mr; s.mw = mw; s.m2r = m2r;
    s.rs2 = alu ^ 32'hA5A5_0000; s.zero = 0; s.tgt = alu + 32'h100; s.f3 = 3'b010; s.br = 0;
    return s;
  endfunction

  // Expected next register contents, written directly from the block's behaviour.
  function automatic exp_t next_model(input exp_t m, input in_t s);
    exp_t n = m;
    if (s.flush) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; n.pcs = 0;
      n.data_known = 1'b0;
    end else if (!s.stall) begin
      n.v   = s.v;
      n.alu = s.alu;
      n.rs2 = s.rs2;
      n.rd  = s.rd;
      n.rw  = s.v && s.rw && (s.rd != 0);
      n.mr  = s.v && s.mr;
      n.mw  = s.v && s.mw;
      n.m2r = s.v && s.m2r;
`ifdef EXMEM_BRANCH_RESOLVE_EN
      n.pcs = s.v && s.br && ((s.f3 == 3'b000 && s.zero) || (s.f3 == 3'b001 && !s.zero));
      n.tgt = s.tgt;
`else
      n.pcs = 0;
      n.tgt = '0;
`endif
      n.data_known = 1'b1;
    end
    return n;
  endfunction

  task automatic compare_outputs(input exp_t e);
    check_eq("mem_valid",      mem_valid,      e.v);
    check_eq("mem_reg_write",  mem_reg_write,  e.rw);
    check_eq("mem_mem_read",   mem_mem_read,   e.mr);
    check_eq("mem_mem_write",  mem_mem_write,  e.mw);
    check_eq("mem_mem_to_reg", mem_mem_to_reg, e.m2r);
    check_eq("mem_pc_src",     mem_pc_src,     e.pcs);
    check_eq("fwd_en",         fwd_en,         e.rw & ~e.mr);
`ifndef EXMEM_BRANCH_RESOLVE_EN
    check_eq("mem_branch_target", mem_branch_target, e.tgt);
`endif
    if (e.data_known) begin
      check_eq("mem_alu_out",  mem_alu_out,  e.alu);
      check_eq("mem_rs2_data", mem_rs2_data, e.rs2);
      check_eq("mem_rd",       mem_rd,       e.rd);
      check_eq("fwd_rd",       fwd_rd,       e.rd);
`ifdef EXMEM_BRANCH_RESOLVE_EN
      check_eq("mem_branch_target", mem_branch_target, e.tgt);
`endif
    end
  endtask

  task automatic cycle(input in_t s);
    exp_t e;
    stall = s.stall; flush = s.flush; ex_valid = s.v; ex_alu_out = s.alu;
    ex_zero = s.zero; ex_rs2_data = s.rs2; ex_rd = s.rd; ex_branch_target = s.tgt;
    ex_funct3 = s.f3; ex_reg_write = s.rw; ex_mem_read = s.mr; ex_mem_write = s.mw;
    ex_mem_to_reg = s.m2r; ex_branch = s.br;
    model = next_model(model, s);
    sb.push_back(model);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_outputs(e);
  endtask

  initial begin
    in_t s;
    exp_t z;
    rst = 1'b1;
    cycle_inputs_idle();
    model = zero_state();
    z = zero_state();
    #12;
    compare_outputs(z);               // reset state
    @(negedge clk);
    rst = 1'b0;

    // Basic load and forwarding
    cycle(ld(1, 32'h0000_1234, 5'd5, 1, 0, 0, 0));
    check_eq("t2_alu", mem_alu_out, 32'h1234);
    check_eq("t2_fwd_rd", fwd_rd, 5'd5);
    check_eq("t2_fwd_en", fwd_en, 1'b1);

    // x0 destination and load-use
    cycle(ld(1, 32'h0000_0042, 5'd0, 1, 0, 0, 0));
    check_eq("t3_rw_x0", mem_reg_write, 1'b0);
    cycle(ld(1, 32'h0000_2000, 5'd7, 1, 1, 0, 1));
    check_eq("t3_fwd_load", fwd_en, 1'b0);

    // Bubble with control asserted, illegal read+write, store
    cycle(ld(0, 32'hDEAD_BEEF, 5'd9, 1, 1, 1, 1));
    cycle(ld(1, 32'h0000_3000, 5'd3, 0, 1, 1, 0));
    cycle(ld(1, 32'h0000_4000, 5'd4, 0, 0, 1, 0));

    // Stall for three cycles with changing inputs, then stall+flush
    cycle(ld(1, 32'h0000_5555, 5'd11, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      s = ld(1, 32'h9000_0000 + i, 5'(20 + i), 1, i[0], 1, 1);
      s.stall = 1;
      cycle(s);
      check_eq("t4_frozen", mem_alu_out, 32'h5555);
    end
    s = ld(1, 32'h7777_7777, 5'd12, 1, 1, 1, 1);
    s.stall = 1; s.flush = 1;
    cycle(s);
    check_eq("t4_flush_valid", mem_valid, 1'b0);

    // Branch stimulus (pc_src only when resolution is built in)
    s = ld(1, 32'h0, 5'd0, 0, 0, 0, 0);
    s.br = 1; s.f3 = 3'b000; s.zero = 1; s.tgt = 32'h80;
    cycle(s);
`ifdef EXMEM_BRANCH_RESOLVE_EN
    check_eq("t5_beq_taken", mem_pc_src, 1'b1);
    check_eq("t5_target", mem_branch_target, 32'h80);
`else
    check_eq("t6_pc_src", mem_pc_src, 1'b0);
    check_eq("t6_target", mem_branch_target, 32'h0);
`endif
    s.f3 = 3'b001; cycle(s);
    s.zero = 0;    cycle(s);
    s.f3 = 3'b100; cycle(s);
    s.f3 = 3'b000; s.zero = 1; s.flush = 1; cycle(s);

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      s = ld(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      s.rs2 = $urandom; s.tgt = $urandom; s.zero = 1'($urandom);
      s.f3 = 3'($urandom_range(0, 2)); s.br = 1'($urandom);
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 6) == 0);
      cycle(s);
    end

    // Asynchronous reset mid-run while a valid instruction is held
    cycle(ld(1, 32'hCAFE_0001, 5'd6, 1, 0, 1, 1));
    check_eq("t1_pre_valid", mem_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    compare_outputs(z);
    model = zero_state();
    @(negedge clk);
    rst = 1'b0;
    cycle(ld(1, 32'h0000_0ABC, 5'd8, 1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic cycle_inputs_idle();
    stall = 0; flush = 0; ex_valid = 0; ex_alu_out = '0; ex_zero = 0; ex_rs2_data = '0;
    ex_rd = '0; ex_branch_target = '0; ex_funct3 = '0; ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0; ex_mem_to_reg = 0; ex_branch = 0;
  endtask

endmodule
